// File: rtl/riscv_bus_pkg.sv
// rtl/riscv_bus_pkg.sv - shared bus types and default widths for the core memory-port arbiters
package riscv_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gnrl_arb2_sel.sv
// rtl/gnrl_arb2_sel.sv - two-way requester select; prio breaks ties, a lone requester always wins
module gnrl_arb2_sel (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt,
  output logic any
);

  // gnt is 0 when nobody requests; callers qualify it with any
  assign gnt = (req0 & req1) ? prio : req1;
  assign any = req0 | req1;

endmodule

// File: rtl/gnrl_dff_arst.sv
// rtl/gnrl_dff_arst.sv - W-bit register with asynchronous active-low reset to RST
module gnrl_dff_arst #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // plain state flop, forced to RST the moment rst_n falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else        q <= d;
  end

endmodule

// File: rtl/gnrl_bus_arb2.sv
// rtl/gnrl_bus_arb2.sv - IFU/LSU round-robin arbiter onto one memory port; ARB_TIMEOUT_EN adds a response timeout
module gnrl_bus_arb2
  import riscv_bus_pkg::*;
#(
  parameter int AW     = BUS_AW,
  parameter int DW     = BUS_DW,
  parameter int TO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic            m0_req_wen,
  input  logic [DW-1:0]   m0_req_wdata,
  input  logic [DW/8-1:0] m0_req_wstrb,
  output logic            m0_rsp_valid,
  output logic [DW-1:0]   m0_rsp_rdata,
  output logic            m0_rsp_err,
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic            m1_req_wen,
  input  logic [DW-1:0]   m1_req_wdata,
  input  logic [DW/8-1:0] m1_req_wstrb,
  output logic            m1_rsp_valid,
  output logic [DW-1:0]   m1_rsp_rdata,
  output logic            m1_rsp_err,
  output logic            s_req_valid,
  input  logic            s_req_ready,
  output logic [AW-1:0]   s_req_addr,
  output logic            s_req_wen,
  output logic [DW-1:0]   s_req_wdata,
  output logic [DW/8-1:0] s_req_wstrb,
  input  logic            s_rsp_valid,
  input  logic [DW-1:0]   s_rsp_rdata,
  input  logic            s_rsp_err
);

  arb_state_e state_q, state_d;
  logic [1:0] state_raw;
  logic       gnt_q, gnt_d;
  logic       prio_q, prio_d;
  logic       in_addr, in_wait;
  logic       req_hs, to_hit;
  logic       sel_prio, sel_gnt, sel_any;

  gnrl_dff_arst #(.W(2)) u_state_dff (.clk(clk), .rst_n(rst_n), .d(state_d), .q(state_raw));
  gnrl_dff_arst #(.W(1)) u_gnt_dff   (.clk(clk), .rst_n(rst_n), .d(gnt_d),   .q(gnt_q));
  gnrl_dff_arst #(.W(1)) u_prio_dff  (.clk(clk), .rst_n(rst_n), .d(prio_d),  .q(prio_q));

  assign state_q = arb_state_e'(state_raw);
  assign in_addr = (state_q == ST_ADDR);
  assign in_wait = (state_q == ST_WAIT);
  assign req_hs  = s_req_valid & s_req_ready;

  // On a WAIT->ADDR hand-off the next winner is picked with the priority being written this cycle
  assign sel_prio = in_wait ? ~gnt_q : prio_q;

  gnrl_arb2_sel u_sel (
    .req0(m0_req_valid),
    .req1(m1_req_valid),
    .prio(sel_prio),
    .gnt (sel_gnt),
    .any (sel_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  gnrl_dff_arst #(.W(CW)) u_cnt_dff (.clk(clk), .rst_n(rst_n), .d(cnt_d), .q(cnt_q));

  // count WAIT cycles from zero at the accept; a real response always beats the timeout
  assign cnt_d  = req_hs ? '0 : (in_wait ? cnt_q + CW'(1) : cnt_q);
  assign to_hit = in_wait & ~s_rsp_valid & (cnt_q == CW'(TO_CYC));
`else
  logic unused_to_cyc;

  // without the timeout TO_CYC has no effect and WAIT only ends on a slave response
  assign unused_to_cyc = ^TO_CYC;
  assign to_hit        = 1'b0;
`endif

  // request path: only the granted master reaches the slave, and only while in ADDR
  always_comb begin
    s_req_valid  = 1'b0;
    s_req_addr   = '0;
    s_req_wen    = 1'b0;
    s_req_wdata  = '0;
    s_req_wstrb  = '0;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    if (in_addr) begin
      if (gnt_q) begin
        s_req_valid  = m1_req_valid;
        s_req_addr   = m1_req_addr;
        s_req_wen    = m1_req_wen;
        s_req_wdata  = m1_req_wdata;
        s_req_wstrb  = m1_req_wstrb;
        m1_req_ready = s_req_ready;
      end else begin
        s_req_valid  = m0_req_valid;
        s_req_addr   = m0_req_addr;
        s_req_wen    = m0_req_wen;
        s_req_wdata  = m0_req_wdata;
        s_req_wstrb  = m0_req_wstrb;
        m0_req_ready = s_req_ready;
      end
    end
  end

  // response path: slave responses outside WAIT are stray and never reach a master
  always_comb begin
    m0_rsp_valid = 1'b0;
    m0_rsp_rdata = '0;
    m0_rsp_err   = 1'b0;
    m1_rsp_valid = 1'b0;
    m1_rsp_rdata = '0;
    m1_rsp_err   = 1'b0;
    if (in_wait && s_rsp_valid) begin
      if (gnt_q) begin
        m1_rsp_valid = 1'b1;
        m1_rsp_rdata = s_rsp_rdata;
        m1_rsp_err   = s_rsp_err;
      end else begin
        m0_rsp_valid = 1'b1;
        m0_rsp_rdata = s_rsp_rdata;
        m0_rsp_err   = s_rsp_err;
      end
    end else if (to_hit) begin
      if (gnt_q) begin
        m1_rsp_valid = 1'b1;
        m1_rsp_err   = 1'b1;
      end else begin
        m0_rsp_valid = 1'b1;
        m0_rsp_err   = 1'b1;
      end
    end
  end

  // transaction sequencing; gnt stays put through ADDR even if the master misbehaves
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          gnt_d   = sel_gnt;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (req_hs) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (s_rsp_valid) begin
          prio_d = ~gnt_q;
          if (sel_any) begin
            gnt_d   = sel_gnt;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (to_hit) begin
          prio_d  = ~gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
